// File: rtl/serv_dbus_pkg.sv
// Shared types and constants for the SERV data-bus bridge.
// Optional bus timeout is enabled with SERV_DBUS_TIMEOUT_EN.
package serv_dbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_RESP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    // Read data returned to the core when an access fails.
    localparam logic [31:0] RDT_ERR = 32'h0;

    // Width of a counter that must hold values 0..limit.
    function automatic int unsigned timer_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/serv_dbus_timer.sv
// Cycle counter that flags when a bus access has been outstanding for TIMEOUT cycles.
// Only instantiated when SERV_DBUS_TIMEOUT_EN is defined.
module serv_dbus_timer
    import serv_dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned W = timer_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // The TIMEOUT-th enabled cycle is the one that reports expiry.
    assign o_expired = i_enable && (count == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable && !o_expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/serv_dbus_bridge.sv
// Registered bridge from the SERV data port to a pipelined Wishbone slave with stall.
// Define SERV_DBUS_TIMEOUT_EN to abort accesses the slave leaves unanswered for TIMEOUT cycles.
module serv_dbus_bridge
    import serv_dbus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_cpu_adr,
    input  logic [31:0] i_cpu_dat,
    input  logic [3:0]  i_cpu_sel,
    input  logic        i_cpu_we,
    input  logic        i_cpu_cyc,
    output logic [31:0] o_cpu_rdt,
    output logic        o_cpu_ack,
    output logic        o_cpu_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic [2:0]  o_dbg_state
);

    // Handshake: the core holds i_cpu_cyc and its fields until o_cpu_ack; the slave
    // accepts stb on a cycle without i_wb_stall and answers with one ack or err cycle.
    state_t state;
    logic   orphan;
    logic   busy;
    logic   resp_ok;
    logic   slv_ack;
    logic   slv_err;
    logic   timeout;
    logic   fail;
    logic   finish;
    logic   deliver;

    assign busy    = (state == S_REQ) || (state == S_WAIT);
    // A response only counts once the strobe has been (or is being) accepted.
    assign resp_ok = (state == S_WAIT) || ((state == S_REQ) && !i_wb_stall);
    assign slv_ack = resp_ok && i_wb_ack;
    assign slv_err = resp_ok && i_wb_err;

`ifdef SERV_DBUS_TIMEOUT_EN
    logic tmr_expired;

    serv_dbus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (state == S_IDLE),
        .i_enable  (busy),
        .o_expired (tmr_expired)
    );

    assign timeout = busy && tmr_expired;
`else
    // TIMEOUT has no effect in this build.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout        = 1'b0;
`endif

    // Error beats ack; a real ack beats a timeout in the same cycle.
    assign fail    = slv_err || (timeout && !slv_ack);
    assign finish  = busy && (slv_ack || fail);
    assign deliver = i_cpu_cyc && !orphan;

    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            orphan    <= 1'b0;
            o_cpu_rdt <= '0;
            o_cpu_ack <= 1'b0;
            o_cpu_err <= 1'b0;
            o_wb_adr  <= '0;
            o_wb_dat  <= '0;
            o_wb_sel  <= '0;
            o_wb_we   <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
        end else begin
            o_cpu_ack <= 1'b0;
            o_cpu_err <= 1'b0;
            // Core abandoned the access: let the bus finish but stay silent.
            if (busy && !i_cpu_cyc) begin
                orphan <= 1'b1;
            end
            if (finish) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
                if (fail) begin
                    o_cpu_rdt <= RDT_ERR;
                end else if (!o_wb_we) begin
                    o_cpu_rdt <= i_wb_rdt;
                end
                o_cpu_ack <= deliver;
                o_cpu_err <= deliver && fail;
                state     <= S_RESP;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_cpu_cyc) begin
                            o_wb_adr <= i_cpu_adr;
                            o_wb_dat <= i_cpu_dat;
                            o_wb_sel <= i_cpu_sel;
                            o_wb_we  <= i_cpu_we;
                            o_wb_cyc <= 1'b1;
                            o_wb_stb <= 1'b1;
                            orphan   <= 1'b0;
                            state    <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (!i_wb_stall) begin
                            o_wb_stb <= 1'b0;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        state <= S_WAIT;
                    end
                    S_RESP: begin
                        // HOLD only if the core saw an ack and may still hold cyc.
                        state <= o_cpu_ack ? S_HOLD : S_IDLE;
                    end
                    S_HOLD: begin
                        if (!i_cpu_cyc) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serv_dbus_bridge.sv
// Directed and randomised checks of serv_dbus_bridge against a behavioural Wishbone slave.
// The timeout scenario runs only when SERV_DBUS_TIMEOUT_EN is defined.
module tb_serv_dbus_bridge;
    import serv_dbus_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_adr = '0;
    logic [31:0] cpu_dat = '0;
    logic [3:0]  cpu_sel = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_cyc = 1'b0;
    logic [31:0] cpu_rdt;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_stall = 1'b0;
    logic [31:0] wb_rdt = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_rdt;

    // Slave model knobs and bookkeeping
    int          stall_n = 0;
    int          resp_delay = 1;
    bit          resp_err = 1'b0;
    logic [31:0] slv_data = '0;
    int          stall_left = 0;
    int          resp_cnt = -1;
    bit          stb_seen = 1'b0;
    int          txn_cnt = 0;

    serv_dbus_bridge #(.TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cpu_adr   (cpu_adr),
        .i_cpu_dat   (cpu_dat),
        .i_cpu_sel   (cpu_sel),
        .i_cpu_we    (cpu_we),
        .i_cpu_cyc   (cpu_cyc),
        .o_cpu_rdt   (cpu_rdt),
        .o_cpu_ack   (cpu_ack),
        .o_cpu_err   (cpu_err),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat),
        .o_wb_sel    (wb_sel),
        .o_wb_we     (wb_we),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .i_wb_stall  (wb_stall),
        .i_wb_rdt    (wb_rdt),
        .i_wb_ack    (wb_ack),
        .i_wb_err    (wb_err),
        .o_dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Slave: decides stall/response at the falling edge for the next rising edge.
    always @(negedge clk) begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_rdt = $urandom;
        if (resp_cnt == 0) begin
            wb_ack   = !resp_err;
            wb_err   = resp_err;
            wb_rdt   = slv_data;
            resp_cnt = -1;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
        end
        if (wb_cyc && wb_stb) begin
            if (!stb_seen) begin
                stb_seen   = 1'b1;
                stall_left = stall_n;
            end
            if (stall_left > 0) begin
                wb_stall = 1'b1;
                stall_left--;
            end else begin
                wb_stall = 1'b0;
                txn_cnt++;
                if (resp_delay == 0) begin
                    wb_ack = !resp_err;
                    wb_err = resp_err;
                    wb_rdt = slv_data;
                end else begin
                    resp_cnt = resp_delay - 1;
                end
            end
        end else begin
            stb_seen = 1'b0;
            wb_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: one core access; cycle 0 is the cycle in which cpu_cyc rises.
    task automatic cpu_access(input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic we,
                              input logic [32:0] exp, input int exp_cyc, input int exp_stb,
                              input int hold_extra, input int quiet);
        int n;
        int stb_n;
        int txn0;
        logic [32:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        txn0    = txn_cnt;
        cpu_adr = adr;
        cpu_dat = dat;
        cpu_sel = sel;
        cpu_we  = we;
        cpu_cyc = 1'b1;
        n = 0;
        stb_n = 0;
        while (!cpu_ack && n < 60) begin
            @(negedge clk);
            n++;
            if (wb_stb) begin
                stb_n++;
                check("wb_adr", wb_adr, adr);
                check("wb_dat", wb_dat, dat);
                check("wb_sel", {28'h0, wb_sel}, {28'h0, sel});
                check("wb_we", wb_we, we);
            end
        end
        check("ack_seen", cpu_ack, 1'b1);
        e = exp_q.pop_front();
        check("ack_cycle", n, exp_cyc);
        check("stb_cycles", stb_n, exp_stb);
        check("cyc_low_at_ack", wb_cyc, 1'b0);
        check("cpu_rdt", cpu_rdt, e[31:0]);
        check("cpu_err", cpu_err, e[32]);
        for (int i = 0; i < hold_extra; i++) begin
            @(negedge clk);
            check("ack_once_hold", cpu_ack, 1'b0);
        end
        @(negedge clk);
        check("ack_once", cpu_ack, 1'b0);
        cpu_cyc = 1'b0;
        for (int i = 0; i < quiet; i++) begin
            @(negedge clk);
            check("ack_quiet", cpu_ack, 1'b0);
        end
        check("one_bus_txn", txn_cnt, txn0 + 1);
        last_rdt = e[31:0];
    endtask

    initial begin
        int st;
        int dl;
        logic        we;
        logic [31:0] d;
        logic [31:0] er;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_rdt", cpu_rdt, 32'h0);
        check("rst_ack", cpu_ack, 1'b0);
        check("rst_err", cpu_err, 1'b0);
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_adr", wb_adr, 32'h0);
        rst_n = 1'b1;
        last_rdt = 32'h0;

        // Read, registered slave, no stall
        stall_n = 0; resp_delay = 1; resp_err = 1'b0; slv_data = 32'hCAFEF00D;
        cpu_access(32'h0000_0040, 32'h0, 4'hF, 1'b0, {1'b0, 32'hCAFEF00D}, 3, 1, 0, 0);

        // Write with three stall cycles; read data must be kept
        stall_n = 3; slv_data = 32'h5555_AAAA;
        cpu_access(32'h0000_0100, 32'h0000_BEEF, 4'b0011, 1'b1, {1'b0, 32'hCAFEF00D}, 6, 4, 0, 0);

        // Combinational slave acks in the acceptance cycle
        stall_n = 0; resp_delay = 0; slv_data = 32'h0BAD_C0DE;
        cpu_access(32'h0000_0203, 32'h0, 4'b1000, 1'b0, {1'b0, 32'h0BAD_C0DE}, 2, 1, 0, 0);

        // Slave error, core keeps cyc two extra cycles
        resp_delay = 1; resp_err = 1'b1; slv_data = 32'h1111_2222;
        cpu_access(32'h0000_0300, 32'h0, 4'hF, 1'b0, {1'b1, RDT_ERR}, 3, 1, 2, 3);
        resp_err = 1'b0;

        // Core drops cyc while the slave is still busy: no ack, bridge returns to idle
        resp_delay = 3; slv_data = 32'h1234_5678;
        @(negedge clk);
        cpu_adr = 32'h0000_0400; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_cyc = 1'b1;
        repeat (2) @(negedge clk);
        check("orphan_in_wait", dbg_state, S_WAIT);
        cpu_cyc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("orphan_no_ack", cpu_ack, 1'b0);
            check("orphan_no_err", cpu_err, 1'b0);
        end
        check("orphan_idle", dbg_state, S_IDLE);
        check("orphan_cyc_low", wb_cyc, 1'b0);

`ifdef SERV_DBUS_TIMEOUT_EN
        // Slave answers far too late: timeout aborts, late ack is ignored
        resp_delay = 8; slv_data = 32'h7777_7777;
        cpu_access(32'h0000_0500, 32'h0, 4'hF, 1'b0, {1'b1, RDT_ERR}, TO + 1, 1, 0, 8);
`endif

        // Reset asserted while waiting for the slave
        resp_delay = 4; slv_data = 32'h9999_0000;
        @(negedge clk);
        cpu_adr = 32'h0000_0600; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_cyc = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_in_wait", dbg_state, S_WAIT);
        rst_n = 1'b0;
        cpu_cyc = 1'b0;
        #1;
        check("rst_mid_cyc", wb_cyc, 1'b0);
        check("rst_mid_stb", wb_stb, 1'b0);
        check("rst_mid_rdt", cpu_rdt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_late_no_ack", cpu_ack, 1'b0);
            check("rst_late_cyc", wb_cyc, 1'b0);
        end
        last_rdt = 32'h0;

        // Normal access after reset
        resp_delay = 1; slv_data = 32'hA5A5_5A5A;
        cpu_access(32'h0000_0700, 32'h0, 4'hF, 1'b0, {1'b0, 32'hA5A5_5A5A}, 3, 1, 0, 0);

        // Randomised mix of reads/writes with varying stall and latency
        for (int k = 0; k < 8; k++) begin
            st = $urandom_range(0, 2);
            dl = $urandom_range(0, 2);
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            stall_n = st; resp_delay = dl; slv_data = d;
            er = we ? last_rdt : d;
            cpu_access($urandom, $urandom, 4'($urandom_range(0, 15)), we, {1'b0, er},
                       2 + st + dl, 1 + st, $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
